// File: rtl/mul_div_if.sv
// Decode-side bundle for the HI/LO multiply/divide unit: operation request in,
// selected HI/LO result and pipeline hazard status out.
interface mul_div_if;
    logic [3:0]  mulCtrl;
    logic        mulEnable;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        mulOutputSel;
    logic [31:0] result;
    logic        busy;
    logic        stall;
    logic        state_dbg;

    // A request is taken only at a rising edge where mulEnable=1 and busy=0;
    // while stall=1 the producer must hold the request stable and re-present it.
    modport slave (
        input  mulCtrl, mulEnable, operandA, operandB, mulOutputSel,
        output result, busy, stall, state_dbg
    );

    modport master (
        output mulCtrl, mulEnable, operandA, operandB, mulOutputSel,
        input  result, busy, stall, state_dbg
    );
endinterface

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO unit: fixed-latency multiply/accumulate and divide with
// commit at the final busy edge, plus direct mthi/mtlo writes.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     reset,
    mul_div_if.slave bus
);
    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic          busy, long_op, is_div, start;
    logic [63:0]   prod_s, prod_u, hilo;
    logic [31:0]   a_abs, b_abs, uq, ur, sq, sr;

    always_comb begin
        long_op = 1'b0;
        is_div  = 1'b0;
        case (bus.mulCtrl)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB: long_op = 1'b1;
            OP_DIV, OP_DIVU: begin
                long_op = 1'b1;
                is_div  = 1'b1;
            end
            default: ;
        endcase
        busy  = (state_q == S_RUN);
        start = bus.mulEnable & long_op & ~busy;
    end

    // Arithmetic works on the latched operands; the low 64 bits of a
    // sign-extended product equal the signed product.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        hilo   = {hi_q, lo_q};
        a_abs  = a_q[31] ? (32'd0 - a_q) : a_q;
        b_abs  = b_q[31] ? (32'd0 - b_q) : b_q;
        uq     = (b_q == 32'd0) ? 32'd0 : a_abs / b_abs;
        ur     = (b_q == 32'd0) ? 32'd0 : a_abs % b_abs;
        // 0x80000000 / -1 falls out naturally: |a| / 1 negated wraps back.
        sq     = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
        sr     = a_q[31] ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (start) begin
            state_d = S_RUN;
            cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            op_d    = bus.mulCtrl;
            a_d     = bus.operandA;
            b_d     = bus.operandB;
        end else if (busy) begin
            if (cnt_q == CW'(1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                case (op_q)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_MADD:  {hi_d, lo_d} = hilo + prod_s;
                    OP_MADDU: {hi_d, lo_d} = hilo + prod_u;
                    OP_MSUB:  {hi_d, lo_d} = hilo - prod_s;
                    OP_DIV: if (b_q != 32'd0) begin
                        hi_d = sr;
                        lo_d = sq;
                    end
                    OP_DIVU: if (b_q != 32'd0) begin
                        hi_d = a_q % b_q;
                        lo_d = a_q / b_q;
                    end
                    default: ;
                endcase
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (bus.mulEnable) begin
            case (bus.mulCtrl)
                OP_MTHI: hi_d = bus.operandA;
                OP_MTLO: lo_d = bus.operandA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.stall     = busy | start;
    assign bus.result    = bus.mulOutputSel ? hi_q : lo_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table of HI/LO operations with a result
// scoreboard, plus hand sequences for busy-time requests and mid-op reset.
module tb_mul_div_unit;
    typedef struct {
        logic [3:0]  ctrl;
        logic        en;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    logic clk;
    logic reset;
    mul_div_if bus_if ();

    mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;
    vec_t        vecs[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        bus_if.mulOutputSel = 1'b0;
        #1 check({name, "_lo"}, bus_if.result, lo);
        bus_if.mulOutputSel = 1'b1;
        #1 check({name, "_hi"}, bus_if.result, hi);
        bus_if.mulOutputSel = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int          n;
        logic [63:0] e;
        @(negedge clk);
        bus_if.mulCtrl      = v.ctrl;
        bus_if.mulEnable    = v.en;
        bus_if.operandA     = v.a;
        bus_if.operandB     = v.b;
        bus_if.mulOutputSel = 1'b0;
        exp_q.push_back({v.hi, v.lo});
        #1 check("stall_at_issue", 32'(bus_if.stall), 32'(v.cycles != 0));
        @(posedge clk);
        @(negedge clk);
        bus_if.mulEnable = 1'b0;
        bus_if.mulCtrl   = 4'd0;
        n = 0;
        while (bus_if.busy && n < 40) begin
            n++;
            check("hold_old_lo", bus_if.result, cur_lo);
            check("stall_busy", 32'(bus_if.stall), 32'd1);
            @(negedge clk);
        end
        check("busy_len", 32'(n), 32'(v.cycles));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check_hilo("op", e[63:32], e[31:0]);
            cur_hi = e[63:32];
            cur_lo = e[31:0];
        end
    endtask

    initial begin
        int          n;
        logic [63:0] p;
        logic [31:0] ra, rb;
        vec_t        v;

        reset               = 1'b1;
        bus_if.mulCtrl      = 4'd0;
        bus_if.mulEnable    = 1'b0;
        bus_if.operandA     = 32'd0;
        bus_if.operandB     = 32'd0;
        bus_if.mulOutputSel = 1'b0;
        #2;
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_stall", 32'(bus_if.stall), 32'd0);
        check_hilo("reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ctrl, en, a, b, expected HI, expected LO, busy cycles (state carries over)
        vecs[0]  = '{4'd1,  1'b1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{4'd2,  1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{4'd3,  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{4'd4,  1'b1, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{4'd3,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{4'd5,  1'b1, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 0};
        vecs[6]  = '{4'd6,  1'b1, 32'h00000001, 32'd0,        32'h12345678, 32'h00000001, 0};
        vecs[7]  = '{4'd7,  1'b1, 32'd3,        32'd4,        32'h12345678, 32'h0000000D, 5};
        vecs[8]  = '{4'd9,  1'b1, 32'd1,        32'hD,        32'h12345678, 32'h00000000, 5};
        vecs[9]  = '{4'd8,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345676, 32'h00000001, 5};
        vecs[10] = '{4'd3,  1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{4'd12, 1'b1, 32'hAAAA5555, 32'd9,        32'h00000001, 32'hFFFFFFFD, 0};
        vecs[12] = '{4'd1,  1'b0, 32'd9,        32'd9,        32'h00000001, 32'hFFFFFFFD, 0};
        vecs[13] = '{4'd9,  1'b1, 32'd2,        32'hFFFFFFFD, 32'h00000002, 32'h00000003, 5};
        vecs[14] = '{4'd4,  1'b1, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[15] = '{4'd1,  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        for (int i = 0; i < 16; i++) run_op(vecs[i]);

        // Random signed/unsigned multiplies against a 64-bit reference product.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(32'hFFFFFFFF, 0);
            rb = $urandom_range(32'hFFFFFFFF, 0);
            if (i % 2 == 0) begin
                p = {32'b0, ra} * {32'b0, rb};
                v = '{4'd2, 1'b1, ra, rb, p[63:32], p[31:0], 5};
            end else begin
                p = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
                v = '{4'd1, 1'b1, ra, rb, p[63:32], p[31:0], 5};
            end
            run_op(v);
        end

        // Divide running; a mult shows up at busy cycle 3 and must be ignored.
        @(negedge clk);
        bus_if.mulCtrl   = 4'd3;
        bus_if.mulEnable = 1'b1;
        bus_if.operandA  = 32'd100;
        bus_if.operandB  = 32'd7;
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clk);
        @(negedge clk);
        bus_if.mulEnable = 1'b0;
        n = 0;
        while (bus_if.busy && n < 40) begin
            n++;
            if (n == 3) begin
                bus_if.mulCtrl   = 4'd1;
                bus_if.mulEnable = 1'b1;
                bus_if.operandA  = 32'd5;
                bus_if.operandB  = 32'd5;
            end
            #1 check("stall_held", 32'(bus_if.stall), 32'd1);
            @(negedge clk);
        end
        check("div_busy_len", 32'(n), 32'd10);
        bus_if.mulEnable = 1'b0;
        bus_if.mulCtrl   = 4'd0;
        p = exp_q.pop_front();
        check_hilo("div_only", p[63:32], p[31:0]);
        @(negedge clk);
        check("no_late_mult", 32'(bus_if.busy), 32'd0);
        check_hilo("div_kept", p[63:32], p[31:0]);

        // Reset pulsed at busy cycle 2 of a mult: abort, no later commit.
        @(negedge clk);
        bus_if.mulCtrl   = 4'd1;
        bus_if.mulEnable = 1'b1;
        bus_if.operandA  = 32'd7;
        bus_if.operandB  = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus_if.mulEnable = 1'b0;
        bus_if.mulCtrl   = 4'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_stall", 32'(bus_if.stall), 32'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(bus_if.busy), 32'd0);
            check("post_rst_lo", bus_if.result, 32'd0);
        end
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        run_op('{4'd2, 1'b1, 32'd3, 32'd5, 32'd0, 32'd15, 5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
